hopfield_update: RTL and testbench
==================================

HOPFIELD_UPDATE -- requirements
Module: hopfield_update

Interface
REQ-001 Parameter MAX_SWEEPS, default 15, range 1..255: sweep limit before abort without convergence.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to load x_init and begin relaxation; sampled only in IDLE.
REQ-005 x_init  input  40  initial state; neuron j at bits [2j+1:2j], 2-bit signed.
REQ-006 y  input  10  signed weighted sum for neuron row_sel, from the combinational prediction stage.
REQ-007 row_sel  output  5  index (0..19) of the neuron being evaluated; also the address of the weight-row store.
REQ-008 xalt_packed  output  40  current neuron state, same packing as x_init; feeds the prediction stage.
REQ-009 busy  output  1  high in ISSUE and EVAL.
REQ-010 done  output  1  one-cycle pulse when relaxation ends.
REQ-011 converged  output  1  valid from done until next start: 1 = fixed point reached, 0 = sweep limit hit.
REQ-012 sweep_cnt  output  8  number of completed sweeps in the current or last run.

Function
REQ-013 Neuron encoding: +1 = 2'b01, -1 = 2'b11; x_init entries of 2'b00 or 2'b10 are loaded as 2'b01.
REQ-014 States: IDLE, ISSUE, EVAL, DONE; reset enters IDLE.
REQ-015 IDLE with start=1: load xalt_packed from x_init, clear sweep_cnt, change flag, and row_sel; converged <= 0; next state ISSUE.
REQ-016 ISSUE: hold row_sel=k for one cycle so the synchronous weight store presents row k; next state EVAL.
REQ-017 EVAL: sample y; y>0 sets neuron k to +1, y<0 sets it to -1, y==0 leaves it unchanged; the change flag is set if the value differs.
REQ-018 Updates are sequential (asynchronous Hopfield): the update of neuron k is visible on xalt_packed before neuron k+1 is issued.
REQ-019 EVAL with k<19: k <= k+1, next state ISSUE; each neuron therefore costs exactly 2 cycles and each sweep 40 cycles.
REQ-020 EVAL with k=19: sweep_cnt increments. If no neuron changed in the sweep (including neuron 19), converged <= 1 and next state is DONE. Otherwise, if the new sweep_cnt equals MAX_SWEEPS, next state is DONE with converged=0. Otherwise clear the change flag, set k <= 0, and go to ISSUE.
REQ-021 DONE: done=1 and busy=0 for exactly one cycle; next state IDLE; xalt_packed, converged, and sweep_cnt hold until the next start.
REQ-022 start in ISSUE, EVAL, or DONE is ignored and not queued.
REQ-023 y is interpreted as two's-complement; 10'h200 (-512) yields -1, 10'h1FF (+511) yields +1.
REQ-024 row_sel never exceeds 19; it is 0 outside ISSUE/EVAL.

Reset
REQ-025 rst_n low asynchronously forces IDLE, xalt_packed=40'h55_5555_5555 (all +1), row_sel=0, busy=0, done=0, converged=0, sweep_cnt=0, change flag=0.
REQ-026 Reset asserted mid-sweep aborts without a done pulse; operation resumes only on a fresh start after deassertion.

Configuration
REQ-027 With HOPFIELD_FLIP_STAT_EN defined, the block adds output flip_cnt [15:0], which counts neuron value changes since the last start, saturates at 16'hFFFF, is cleared on start and reset, and holds after done.
REQ-028 Without HOPFIELD_FLIP_STAT_EN, the flip_cnt port and counter do not exist, and all other behaviour is identical.

Verification
REQ-029 Reset: rst_n=0 during busy -> next sample xalt_packed=40'h5555555555, busy=0, done=0, sweep_cnt=0, no done pulse.
REQ-030 Fixed point: x_init=40'h5555555555, y held at +5, start at cycle 0 -> done in cycle 41, converged=1, sweep_cnt=1, state unchanged, flip_cnt=0 if enabled.
REQ-031 Full flip: x_init=40'hFFFFFFFFFF, y held at +3 -> done in cycle 81, converged=1, sweep_cnt=2, xalt_packed=40'h5555555555, flip_cnt=20 if enabled.
REQ-032 Oscillation: bench drives y = -4 when x[row_sel]=+1 and +4 otherwise, MAX_SWEEPS=4 -> done in cycle 161, converged=0, sweep_cnt=4.
REQ-033 Zero and extreme sums: y=0 on neuron 3 keeps its x_init value; y=10'h200 on neuron 5 gives 2'b11; x_init entry 2'b10 loads as 2'b01.
REQ-034 start pulsed while busy=1 -> no restart; timing and result match the run without the extra pulse.

Source files
------------

// File: rtl/hopfield_update.sv
// Sequential Hopfield relaxation controller: one neuron per ISSUE/EVAL pair.
// Optional flip counter output enabled by defining HOPFIELD_FLIP_STAT_EN.
module hopfield_update #(
    parameter int unsigned MAX_SWEEPS = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [39:0] x_init,
    input  logic [9:0]  y,
    output logic [4:0]  row_sel,
    output logic [39:0] xalt_packed,
    output logic        busy,
    output logic        done,
    output logic        converged,
    output logic [7:0]  sweep_cnt
`ifdef HOPFIELD_FLIP_STAT_EN
    ,
    output logic [15:0] flip_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EVAL  = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t      state;
    logic        change_flag;
    logic [5:0]  bit_idx;
    logic [1:0]  cur;
    logic [1:0]  nv;
    logic        changed;
    logic        chg_any;
    logic        last;
    logic [7:0]  sweep_nxt;
    logic [39:0] x_load;

    always_comb begin
        bit_idx   = {row_sel, 1'b0};
        cur       = xalt_packed[bit_idx +: 2];
        nv        = cur;
        if (y[9])
            nv = 2'b11;
        else if (|y)
            nv = 2'b01;
        changed   = (nv != cur);
        chg_any   = change_flag | changed;
        last      = (row_sel == 5'd19);
        sweep_nxt = sweep_cnt + 8'd1;
    end

    // Only the -1 code survives loading; every other pattern becomes +1.
    always_comb begin
        x_load = '0;
        for (int j = 0; j < 20; j++)
            x_load[2*j +: 2] = (x_init[2*j +: 2] == 2'b11) ? 2'b11 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            xalt_packed <= 40'h55_5555_5555;
            row_sel     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            sweep_cnt   <= '0;
            change_flag <= 1'b0;
`ifdef HOPFIELD_FLIP_STAT_EN
            flip_cnt    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        xalt_packed <= x_load;
                        sweep_cnt   <= '0;
                        change_flag <= 1'b0;
                        row_sel     <= '0;
                        converged   <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ISSUE;
`ifdef HOPFIELD_FLIP_STAT_EN
                        flip_cnt    <= '0;
`endif
                    end
                end
                ISSUE: begin
                    state <= EVAL;
                end
                EVAL: begin
                    xalt_packed[bit_idx +: 2] <= nv;
`ifdef HOPFIELD_FLIP_STAT_EN
                    if (changed && flip_cnt != 16'hFFFF)
                        flip_cnt <= flip_cnt + 16'd1;
`endif
                    if (!last) begin
                        row_sel     <= row_sel + 5'd1;
                        change_flag <= chg_any;
                        state       <= ISSUE;
                    end else begin
                        sweep_cnt <= sweep_nxt;
                        row_sel   <= '0;
                        if (!chg_any) begin
                            converged <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= FIN;
                        end else if (sweep_nxt == 8'(MAX_SWEEPS)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            change_flag <= 1'b0;
                            state       <= ISSUE;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hopfield_update.sv
// Bench for hopfield_update: directed table runs, reset abort, and random
// weight-matrix runs checked against an integer-level relaxation model.
module tb_hopfield_update;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [39:0] x_init = '0;
    logic [9:0]  y;
    logic [4:0]  row_sel;
    logic [39:0] xalt_packed;
    logic        busy;
    logic        done;
    logic        converged;
    logic [7:0]  sweep_cnt;
`ifdef HOPFIELD_FLIP_STAT_EN
    logic [15:0] flip_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // y source: 0 const, 1 anti-follow, 2 per-row table, 3 weight matrix
    int          mode = 0;
    logic [9:0]  yc = '0;
    logic [9:0]  yrow [20];
    int          W [20][20];

    always #5 clk = ~clk;

    hopfield_update #(.MAX_SWEEPS(MAXS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .x_init      (x_init),
        .y           (y),
        .row_sel     (row_sel),
        .xalt_packed (xalt_packed),
        .busy        (busy),
        .done        (done),
        .converged   (converged),
        .sweep_cnt   (sweep_cnt)
`ifdef HOPFIELD_FLIP_STAT_EN
        ,
        .flip_cnt    (flip_cnt)
`endif
    );

    function automatic int sval(input logic [1:0] e);
        return (e == 2'b11) ? -1 : 1;
    endfunction

    function automatic logic [9:0] y_fn(input int m, input logic [9:0] c,
                                        input logic [39:0] x, input logic [4:0] r);
        int k;
        int s;
        k = int'(r);
        if (k > 19) return '0;
        case (m)
            0: return c;
            1: return (sval(x[2*k +: 2]) > 0) ? -10'sd4 : 10'sd4;
            2: return yrow[k];
            default: begin
                s = 0;
                for (int j = 0; j < 20; j++)
                    s += W[k][j] * sval(x[2*j +: 2]);
                return 10'(s);
            end
        endcase
    endfunction

    always_comb y = y_fn(mode, yc, xalt_packed, row_sel);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [39:0] xi;
        int          m;
        logic [9:0]  yv;
        bit          pulse;
        logic [39:0] ex;
        bit          ec;
        int          es;
        int          ef;
    } vec_t;

    // Relaxation model over integer spins, weight-matrix source only.
    task automatic model(input logic [39:0] xi, output logic [39:0] xo,
                         output int sw, output bit conv, output int flips);
        int s [20];
        int sum;
        int nvv;
        bit chg;
        for (int j = 0; j < 20; j++) s[j] = sval(xi[2*j +: 2]);
        sw = 0; conv = 0; flips = 0;
        forever begin
            chg = 0;
            for (int k = 0; k < 20; k++) begin
                sum = 0;
                for (int j = 0; j < 20; j++) sum += W[k][j] * s[j];
                nvv = (sum > 0) ? 1 : (sum < 0) ? -1 : s[k];
                if (nvv != s[k]) begin chg = 1; flips++; end
                s[k] = nvv;
            end
            sw++;
            if (!chg) begin conv = 1; break; end
            if (sw == MAXS) break;
        end
        xo = '0;
        for (int j = 0; j < 20; j++) xo[2*j +: 2] = (s[j] < 0) ? 2'b11 : 2'b01;
    endtask

    task automatic run(input vec_t v, input string tag);
        int  n;
        bit  bad_busy;
        bit  bad_row;
        mode = v.m;
        yc = v.yv;
        @(negedge clk);
        x_init = v.xi;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        bad_busy = 0;
        bad_row = 0;
        while (n < 2000) begin
            if (v.pulse && n == 10) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (done) break;
            if (!busy) bad_busy = 1;
            if (row_sel > 5'd19) bad_row = 1;
        end
        chk({tag, " cycles"}, 64'(n), 64'(40 * v.es));
        chk({tag, " done"}, 64'(done), 64'd1);
        chk({tag, " busy_run"}, 64'(bad_busy), 64'd0);
        chk({tag, " row_rng"}, 64'(bad_row), 64'd0);
        chk({tag, " busy_done"}, 64'(busy), 64'd0);
        chk({tag, " conv"}, 64'(converged), 64'(v.ec));
        chk({tag, " sweeps"}, 64'(sweep_cnt), 64'(v.es));
        chk({tag, " x"}, 64'(xalt_packed), 64'(v.ex));
`ifdef HOPFIELD_FLIP_STAT_EN
        chk({tag, " flips"}, 64'(flip_cnt), 64'(v.ef));
`endif
        @(posedge clk);
        #1;
        chk({tag, " pulse1"}, 64'(done), 64'd0);
        chk({tag, " hold_x"}, 64'(xalt_packed), 64'(v.ex));
        chk({tag, " hold_sw"}, 64'(sweep_cnt), 64'(v.es));
        chk({tag, " row0"}, 64'(row_sel), 64'd0);
    endtask

    vec_t tbl [7];
    vec_t rv;

    initial begin
        bit seen;
        for (int j = 0; j < 20; j++) yrow[j] = 10'd1;
        yrow[3] = 10'd0;
        yrow[5] = 10'h200;
        for (int k = 0; k < 20; k++)
            for (int j = 0; j < 20; j++) W[k][j] = 0;

        tbl[0] = '{40'h55_5555_5555, 0, 10'd5, 0, 40'h55_5555_5555, 1, 1, 0};
        tbl[1] = '{40'hFF_FFFF_FFFF, 0, 10'd3, 0, 40'h55_5555_5555, 1, 2, 20};
        tbl[2] = '{40'h55_5555_5555, 1, 10'd0, 0, 40'h55_5555_5555, 0, 4, 80};
        tbl[3] = '{40'h55_5555_55E5, 2, 10'd0, 0, 40'h55_5555_5DD5, 1, 2, 1};
        tbl[4] = '{40'h55_5555_5555, 0, 10'h200, 0, 40'hFF_FFFF_FFFF, 1, 2, 20};
        tbl[5] = '{40'hFF_FFFF_FFFF, 0, 10'd3, 1, 40'h55_5555_5555, 1, 2, 20};
        tbl[6] = '{40'hF0_F0F0_F0F0, 0, 10'd0, 0, 40'hF5_F5F5_F5F5, 1, 1, 0};

        #12;
        chk("rst x", 64'(xalt_packed), 64'h55_5555_5555);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst sweep", 64'(sweep_cnt), 64'd0);
        chk("rst conv", 64'(converged), 64'd0);
        chk("rst row", 64'(row_sel), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 7; i++)
            run(tbl[i], $sformatf("tbl%0d", i));

        // reset in the middle of a sweep
        mode = 0;
        yc = 10'd3;
        @(negedge clk);
        x_init = 40'hFF_FFFF_FFFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid x", 64'(xalt_packed), 64'h55_5555_5555);
        chk("mid busy", 64'(busy), 64'd0);
        chk("mid done", 64'(done), 64'd0);
        chk("mid sweep", 64'(sweep_cnt), 64'd0);
        chk("mid row", 64'(row_sel), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1;
        end
        chk("mid no_resume", 64'(seen), 64'd0);

        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 20; k++)
                for (int j = 0; j < 20; j++)
                    W[k][j] = int'($urandom_range(0, 6)) - 3;
            rv.xi = {$urandom(), $urandom()};
            rv.m = 3;
            rv.yv = '0;
            rv.pulse = (r % 3 == 0);
            model(rv.xi, rv.ex, rv.es, rv.ec, rv.ef);
            run(rv, $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
